// File: rtl/color_scrambler_pipe_pkg.sv
// Shared constants, types and helpers for the colour scrambler pipeline.
// Optional inversion is enabled with COLOR_SCRAMBLER_INVERT_EN.
package color_pkg;

  localparam int CH_W_DEF   = 4;
  localparam int NUM_CH_DEF = 3;
  localparam int SEL_W_DEF  = $clog2(NUM_CH_DEF + 1);

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  typedef logic [CH_W_DEF-1:0]  chan_t;
  typedef logic [SEL_W_DEF-1:0] sel_t;
  typedef logic [NUM_CH_DEF*SEL_W_DEF-1:0] route_t;

  // Output i takes input (i + rot) mod NUM_CH.
  function automatic route_t rot_sel(input sel_t rot);
    route_t r;
    int     k;
    r = '0;
    for (int i = 0; i < NUM_CH_DEF; i++) begin
      k = i + int'(rot);
      if (k >= NUM_CH_DEF) k = k - NUM_CH_DEF;
      r[i*SEL_W_DEF +: SEL_W_DEF] = sel_t'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/color_scrambler_pipe_if.sv
// Pixel/routing bundle between the video source and the scrambler.
// inv_i exists only when COLOR_SCRAMBLER_INVERT_EN is defined.
interface color_scrambler_pipe_if #(
  parameter int CH_W   = color_pkg::CH_W_DEF,
  parameter int NUM_CH = color_pkg::NUM_CH_DEF,
  parameter int SEL_W  = $clog2(NUM_CH + 1)
) ();

  logic [NUM_CH*SEL_W-1:0] sel_i;
  logic                    mode_auto_i;
`ifdef COLOR_SCRAMBLER_INVERT_EN
  logic [NUM_CH-1:0]       inv_i;
`endif
  logic                    frame_start_i;
  logic                    valid_i;
  logic [NUM_CH*CH_W-1:0]  pix_i;

  logic                    valid_o;
  logic                    frame_start_o;
  logic [NUM_CH*CH_W-1:0]  pix_o;
  logic [NUM_CH*SEL_W-1:0] active_sel_o;

  modport master (
`ifdef COLOR_SCRAMBLER_INVERT_EN
    output inv_i,
`endif
    output sel_i,
    output mode_auto_i,
    output frame_start_i,
    output valid_i,
    output pix_i,
    input  valid_o,
    input  frame_start_o,
    input  pix_o,
    input  active_sel_o
  );

  modport slave (
`ifdef COLOR_SCRAMBLER_INVERT_EN
    input  inv_i,
`endif
    input  sel_i,
    input  mode_auto_i,
    input  frame_start_i,
    input  valid_i,
    input  pix_i,
    output valid_o,
    output frame_start_o,
    output pix_o,
    output active_sel_o
  );

endinterface

// File: rtl/color_scrambler_pipe_sync_2ff.sv
// Two-flop synchroniser for slow switch inputs, cleared by rst_n.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/color_scrambler_pipe.sv
// Two-stage per-channel colour router with frame-aligned routing updates.
// Define COLOR_SCRAMBLER_INVERT_EN to add per-channel output inversion.
module color_scrambler_pipe
  import color_pkg::*;
#(
  parameter int CH_W            = CH_W_DEF,
  parameter int NUM_CH          = NUM_CH_DEF,
  parameter int SEL_W           = $clog2(NUM_CH + 1),
  parameter int FRAMES_PER_STEP = 60
) (
  input logic                   clk,
  input logic                   rst_n,
  color_scrambler_pipe_if.slave bus
);

  localparam int PW    = NUM_CH * CH_W;
  localparam int SW    = NUM_CH * SEL_W;
  localparam int CNT_W =
    (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [SEL_W-1:0] ROT_LAST =
    SEL_W'(NUM_CH - 1);

  function automatic logic [SW-1:0] perm(
    input logic [SEL_W-1:0] r
  );
    logic [SW-1:0] p;
    int            k;
    p = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = i + int'(r);
      if (k >= NUM_CH) k = k - NUM_CH;
      p[i*SEL_W +: SEL_W] = SEL_W'(k);
    end
    return p;
  endfunction

  localparam logic [SW-1:0] IDENT = perm(SEL_W'(0));

  logic [SW-1:0]    sel_s;
  logic             mode_s;

  logic [PW-1:0]    s1_pix;
  logic             s1_valid;
  logic             s1_fs;

  logic [PW-1:0]    pix_q;
  logic             valid_q;
  logic             fs_q;
  logic [PW-1:0]    mux_pix;

  logic             mode_q;
  logic [SW-1:0]    act_q;
  logic [SW-1:0]    act_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_nx;
  logic [SEL_W-1:0] rot_q;
  logic [SEL_W-1:0] rot_b;
  logic [SEL_W-1:0] rot_nx;

  sync_2ff #(.W(SW)) u_sync_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.sel_i),
    .q     (sel_s)
  );

  sync_2ff #(.W(1)) u_sync_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.mode_auto_i),
    .q     (mode_s)
  );

`ifdef COLOR_SCRAMBLER_INVERT_EN
  logic [NUM_CH-1:0] inv_s;
  logic [NUM_CH-1:0] inv_q;

  sync_2ff #(.W(NUM_CH)) u_sync_inv (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.inv_i),
    .q     (inv_s)
  );
`endif

  // Counter/rot only carry over between consecutive auto frames.
  always_comb begin
    cnt_b  = mode_q ? cnt_q : '0;
    rot_b  = mode_q ? rot_q : '0;
    cnt_nx = '0;
    rot_nx = '0;
    act_nx = sel_s;
    if (mode_s) begin
      if (cnt_b == CNT_LAST) begin
        cnt_nx = '0;
        rot_nx = (rot_b == ROT_LAST) ?
                 '0 : rot_b + SEL_W'(1);
      end else begin
        cnt_nx = cnt_b + CNT_W'(1);
        rot_nx = rot_b;
      end
      act_nx = perm(rot_nx);
    end
  end

  always_comb begin
    logic [SEL_W-1:0] code;
    logic [CH_W-1:0]  ch;
    mux_pix = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      code = act_q[i*SEL_W +: SEL_W];
      ch   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (code == SEL_W'(k)) ch = s1_pix[k*CH_W +: CH_W];
      end
`ifdef COLOR_SCRAMBLER_INVERT_EN
      if (inv_q[i]) ch = ~ch;
`endif
      mux_pix[i*CH_W +: CH_W] = ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pix   <= '0;
      s1_valid <= 1'b0;
      s1_fs    <= 1'b0;
      pix_q    <= '0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      mode_q   <= 1'b0;
      act_q    <= IDENT;
      cnt_q    <= '0;
      rot_q    <= '0;
`ifdef COLOR_SCRAMBLER_INVERT_EN
      inv_q    <= '0;
`endif
    end else begin
      s1_pix   <= bus.pix_i;
      s1_valid <= bus.valid_i;
      s1_fs    <= bus.frame_start_i;
      valid_q  <= s1_valid;
      fs_q     <= s1_fs;
      pix_q    <= s1_valid ? mux_pix : '0;
      if (bus.frame_start_i) begin
        mode_q <= mode_s;
        act_q  <= act_nx;
        cnt_q  <= cnt_nx;
        rot_q  <= rot_nx;
`ifdef COLOR_SCRAMBLER_INVERT_EN
        inv_q  <= inv_s;
`endif
      end
    end
  end

  assign bus.valid_o       = valid_q;
  assign bus.frame_start_o = fs_q;
  assign bus.pix_o         = pix_q;
  assign bus.active_sel_o  = act_q;

endmodule

// File: tb/tb_color_scrambler_pipe.sv
// Randomised bench for color_scrambler_pipe against a frame-level model.
// Switches only change at least three cycles before a frame start.
module tb_color_scrambler_pipe;

  localparam int CH_W   = 4;
  localparam int NUM_CH = 3;
  localparam int SEL_W  = 2;
  localparam int FPS    = 2;
  localparam int PW     = NUM_CH * CH_W;
  localparam int SW     = NUM_CH * SEL_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  color_scrambler_pipe_if #(
    .CH_W   (CH_W),
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) bus ();

  color_scrambler_pipe #(
    .CH_W            (CH_W),
    .NUM_CH          (NUM_CH),
    .SEL_W           (SEL_W),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          v;
    logic          fs;
    logic [PW-1:0] pix;
  } exp_t;

  exp_t q[$];
  int   sw_sel[NUM_CH];
  bit   sw_auto;
  int   route[NUM_CH];
  int   auto_frames;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] pack_route(input int r[NUM_CH]);
    logic [SW-1:0] x;
    x = '0;
    for (int i = 0; i < NUM_CH; i++)
      x[i*SEL_W +: SEL_W] = r[i][SEL_W-1:0];
    return x;
  endfunction

  function automatic logic [PW-1:0] route_pix(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (route[i] < NUM_CH)
        r[i*CH_W +: CH_W] = p[route[i]*CH_W +: CH_W];
    return r;
  endfunction

  task automatic set_identity();
    foreach (route[i]) route[i] = i;
    auto_frames = 0;
  endtask

  task automatic push_idle();
    exp_t e;
    e.v = 1'b0; e.fs = 1'b0; e.pix = '0;
    q.push_back(e);
  endtask

  task automatic cycle(input bit fs, input bit v,
                       input logic [PW-1:0] p);
    exp_t e;
    int   rot;
    @(negedge clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      check("valid_o", bus.valid_o, e.v);
      check("frame_start_o", bus.frame_start_o, e.fs);
      check("pix_o", bus.pix_o, e.pix);
    end
    check("active_sel_o", bus.active_sel_o, pack_route(route));
    bus.frame_start_i = fs;
    bus.valid_i       = v;
    bus.pix_i         = p;
    bus.sel_i         = pack_route(sw_sel);
    bus.mode_auto_i   = sw_auto;
    if (fs) begin
      if (sw_auto) begin
        auto_frames++;
        rot = (auto_frames / FPS) % NUM_CH;
        foreach (route[i]) route[i] = (i + rot) % NUM_CH;
      end else begin
        auto_frames = 0;
        route = sw_sel;
      end
    end
    e.v   = v;
    e.fs  = fs;
    e.pix = v ? route_pix(p) : '0;
    q.push_back(e);
  endtask

  task automatic px(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) cycle(1'b0, $urandom_range(0, 3) != 0, PW'($urandom));
      else     cycle(1'b0, 1'b1, 12'h321);
    end
  endtask

  task automatic frame(input int n, input bit rnd);
    if (rnd) cycle(1'b1, $urandom_range(0, 3) != 0, PW'($urandom));
    else     cycle(1'b1, 1'b1, 12'h321);
    px(n - 1, rnd);
  endtask

  initial begin
    bus.sel_i         = 6'h24;
    bus.mode_auto_i   = 1'b0;
    bus.frame_start_i = 1'b0;
    bus.valid_i       = 1'b0;
    bus.pix_i         = '0;
    foreach (sw_sel[i]) sw_sel[i] = i;
    sw_auto = 1'b0;
    set_identity();

    repeat (2) @(negedge clk);
    check("reset valid_o", bus.valid_o, 0);
    check("reset frame_start_o", bus.frame_start_o, 0);
    check("reset pix_o", bus.pix_o, 0);
    check("reset active_sel_o", bus.active_sel_o, 6'h24);
    rst_n = 1'b1;
    push_idle();
    push_idle();

    px(4, 1'b0);
    frame(4, 1'b0);

    sw_sel = '{2, 1, 0};
    px(4, 1'b0);
    frame(5, 1'b0);

    sw_sel[0] = 3;
    px(3, 1'b0);
    frame(4, 1'b0);
    cycle(1'b0, 1'b0, 12'h321);
    px(2, 1'b0);

    sw_sel  = '{0, 1, 2};
    sw_auto = 1'b1;
    px(3, 1'b0);
    repeat (5) frame(5, 1'b0);

    sw_sel  = '{2, 1, 0};
    sw_auto = 1'b0;
    px(3, 1'b0);
    frame(5, 1'b0);
    sw_auto = 1'b1;
    px(3, 1'b0);
    repeat (3) frame(5, 1'b0);

    px(3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset valid_o", bus.valid_o, 0);
    check("mid-reset frame_start_o", bus.frame_start_o, 0);
    check("mid-reset pix_o", bus.pix_o, 0);
    check("mid-reset active_sel_o", bus.active_sel_o, 6'h24);
    bus.valid_i       = 1'b0;
    bus.frame_start_i = 1'b0;
    bus.pix_i         = '0;
    q.delete();
    set_identity();
    @(negedge clk);
    rst_n = 1'b1;
    push_idle();
    push_idle();
    px(4, 1'b1);

    repeat (40) begin
      frame($urandom_range(2, 8), 1'b1);
      if ($urandom_range(0, 2) == 0)
        foreach (sw_sel[i]) sw_sel[i] = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) sw_auto = !sw_auto;
      px(3, 1'b1);
    end
    px(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/color_scrambler_pipe.md
Name: color_scrambler_pipe

Overview:
- Parametrised, pipelined successor to the combinational per-channel colour router in the VGA pixel path.
- Each output colour channel selects any input channel, or forces zero.
- Routing changes from the board switches are synchronised and applied only at frame boundaries, so there is no mid-frame tearing.
- Adds an auto-rotate mode that cycles the channel permutation every FRAMES_PER_STEP frames.

Parameters:
- CH_W, 4: bits per colour channel.
- NUM_CH, 3: number of colour channels. Channel 0 = R, 1 = G, 2 = B.
- SEL_W, $clog2(NUM_CH+1): width of one select field.
- FRAMES_PER_STEP, 60: frame starts per auto-rotation step. Must be ≥ 1.

Ports:
- clk, in, 1: pixel clock.
- rst_n, in, 1: asynchronous active-low reset.
- sel_i, in, NUM_CH*SEL_W: switch-driven routing, asynchronous to clk. Field i (bits [i*SEL_W +: SEL_W]) selects the source for output channel i.
- mode_auto_i, in, 1: switch-driven, asynchronous. 1 = auto-rotate, 0 = manual.
- frame_start_i, in, 1: one-cycle strobe on the first pixel of a frame. Independent of valid_i.
- valid_i, in, 1: pixel is in the active area.
- pix_i, in, NUM_CH*CH_W: input pixel. Channel i is at bits [i*CH_W +: CH_W].
- valid_o, out, 1: valid_i delayed 2 cycles.
- frame_start_o, out, 1: frame_start_i delayed 2 cycles.
- pix_o, out, NUM_CH*CH_W: routed pixel.
- active_sel_o, out, NUM_CH*SEL_W: routing currently in effect, in the same encoding as sel_i.

Behaviour:
- Reset (async assert, sync deassert handled by the top level):
  - valid_o = 0, frame_start_o = 0, pix_o = 0.
  - Synchroniser flops = 0.
  - active_sel reset value is identity: field i = i.
  - Frame counter = 0, rotation index = 0.
- Synchronisation: sel_i and mode_auto_i each pass through a 2-flop synchroniser. Values change at most 2 cycles after the input changes.
- Shadow latch: on any clock edge where frame_start_i = 1, the following are loaded simultaneously. They hold at all other times.
  - mode_q <= synchronised mode.
  - active_sel <= manual fields (mode 0) or the rotation permutation (mode 1).
- Select decode: code k < NUM_CH selects input channel k. Any code ≥ NUM_CH drives that output channel to all zeros.
- Pipeline, fixed 2-cycle latency:
  - Stage 1 registers pix_i, valid_i and frame_start_i.
  - Stage 2 applies the mux using active_sel and registers the outputs.
  - The pixel sampled together with frame_start_i is routed with the newly latched selection.
- Blanking: pix_o = 0 whenever valid_o = 0, regardless of routing.
- Auto mode:
  - Routing is a cyclic rotation: output i takes input (i + rot) mod NUM_CH.
  - At each frame_start_i with mode auto, the frame counter increments.
  - When the counter reaches FRAMES_PER_STEP-1, it wraps to 0 and rot increments. rot wraps from NUM_CH-1 to 0.
  - The permutation latched at a frame start uses rot as updated on that same edge.
  - FRAMES_PER_STEP = 1 means rot advances on every frame.
- Leaving auto mode (sampled 0 at a frame start): frame counter and rot clear to 0, and manual routing is latched on the same edge.
- Switch changes without a frame_start_i have no effect on pix_o.
- Reset mid-frame: all state clears immediately. The output is blank until valid_i returns 2 cycles later, with identity routing until the next frame_start_i.

Optional Feature:
- Macro: COLOR_SCRAMBLER_INVERT_EN.
- Defined:
  - Adds input inv_i [NUM_CH], asynchronous, synchronised with 2 flops and latched at frame_start_i like sel_i.
  - Output channel i is bitwise inverted after selection when its latched bit is 1. A zero-forced channel becomes all ones.
  - Blanking still forces 0. Latency is unchanged.
- Undefined: port absent, no inversion logic.

Decomposition:
- Package color_pkg:
  - CH_W and NUM_CH defaults.
  - Channel index constants CH_R = 0, CH_G = 1, CH_B = 2.
  - Typedefs for channel value and select code.
  - Function rot_sel(rot) returning the packed rotation permutation.
- One sub-module, sync_2ff: parametrised-width 2-flop synchroniser, reset to 0 via rst_n. Instantiated once per asynchronous input group.

Test Plan:
- Reset then identity: pix_i = {B=0x3, G=0x2, R=0x1}, valid_i = 1 → two cycles later pix_o = {0x3, 0x2, 0x1}, valid_o = 1.
- Manual swap at frame boundary: set sel_i fields {R←2, G←1, B←0} mid-frame → pix_o unchanged until the pixel accompanying the next frame_start_i, which outputs {B=0x1, G=0x2, R=0x3}.
- Zero code: field R = 3 → R channel of pix_o = 0, other channels unaffected. With valid_i = 0 → pix_o = 0.
- Auto rotate with FRAMES_PER_STEP = 2: mode_auto_i = 1 → rot steps 0→1 after 2 frames, 1→2 after 4 frames, 2→0 after 6 frames. At rot = 1, output R = input G.
- Auto exit: drop mode_auto_i at rot = 2 → at the next frame start, manual routing applies and the internal rot reads 0 on re-entry.
- Async reset asserted mid-pipeline with valid_i = 1 → valid_o, pix_o and frame_start_o go 0 immediately, and active_sel_o = identity.
